// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
// Fetch handshake between the program-counter generator and instruction memory.
//   pc_current_o  : current fetch address (driven by pc_gen)
//   pc_plus4_o    : pc_current_o + 4, modulo 2^XLEN (driven by pc_gen)
//   fetch_valid_o : pc_current_o is a valid fetch request (driven by pc_gen)
//   fetch_ready_i : memory accepts the current address (driven by memory)
// Modports: master = pc_gen side, slave = instruction-memory side.
// -----------------------------------------------------------------------------
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_current_o;
  logic [XLEN-1:0] pc_plus4_o;
  logic            fetch_valid_o;
  logic            fetch_ready_i;

  modport master (
    output pc_current_o,
    output pc_plus4_o,
    output fetch_valid_o,
    input  fetch_ready_i
  );

  modport slave (
    input  pc_current_o,
    input  pc_plus4_o,
    input  fetch_valid_o,
    output fetch_ready_i
  );
endinterface

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator: holds the fetch address, selects the next PC
// (sequential, redirect, trap entry, mret return) and drives a valid/ready
// fetch request toward instruction memory.
//
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   stall_i             : hold the PC
//   redirect_valid_i/
//   redirect_target_i   : taken branch/jump and its target
//   trap_valid_i/
//   trap_vector_i       : trap entry, bits [1:0] of the vector are ignored
//   mret_valid_i/mepc_i : return from trap
//   misalign_o          : one-cycle pulse after a misaligned redirect
//   misalign_addr_o     : offending target of the last misaligned redirect
//   fetch               : pc_gen_if master (pc, pc+4, valid, ready)
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            mret_valid_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  pc_gen_if.master        fetch
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MIS_HALT = 2'd2
  } state_t;

  // Low address bits that must be zero for a legal instruction address.
  localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);
  localparam logic [XLEN-1:0] WORD_MASK  = XLEN'(3);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] mret_pc;
  logic            target_misaligned;

  // Plain XLEN-bit add: the carry out is dropped, so the PC wraps silently.
  assign pc_plus4          = pc_q + XLEN'(4);
  assign trap_pc           = trap_vector_i & ~WORD_MASK;
  assign mret_pc           = mepc_i & ~ALIGN_MASK;
  assign target_misaligned = |(redirect_target_i & ALIGN_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VECTOR;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_d      = 1'b0;  // pulse: only set on the deciding edge
    misalign_addr_d = misalign_addr_q;

    unique case (state_q)
      ST_BOOT: begin
        // Single hold cycle after reset; a trap is still honoured here.
        state_d = ST_RUN;
        if (trap_valid_i) begin
          pc_d = trap_pc;
        end
      end

      ST_RUN: begin
        // Control-flow changes override stall and do not wait for ready:
        // the pending request is simply replaced.
        if (trap_valid_i) begin
          pc_d = trap_pc;
        end else if (mret_valid_i) begin
          pc_d = mret_pc;
        end else if (redirect_valid_i) begin
          if (target_misaligned) begin
            misalign_d      = 1'b1;
            misalign_addr_d = redirect_target_i;
            state_d         = ST_MIS_HALT;
          end else begin
            pc_d = redirect_target_i;
          end
        end else if (!stall_i && fetch.fetch_ready_i) begin
          pc_d = pc_plus4;
        end
      end

      ST_MIS_HALT: begin
        // Frozen until the core takes the misalignment trap.
        if (trap_valid_i) begin
          pc_d    = trap_pc;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign fetch.pc_current_o  = pc_q;
  assign fetch.pc_plus4_o    = pc_plus4;
  assign fetch.fetch_valid_o = (state_q == ST_RUN);
  assign misalign_o          = misalign_q;
  assign misalign_addr_o     = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
// Two pc_gen instances (IALIGN=32 and IALIGN=16, both RESET_VECTOR=0x100)
// share one set of stimulus. Directed scenarios check literal expected values;
// a randomized run checks against a behavioural model of the next-PC rules.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall;
  logic        redir_v;
  logic [31:0] redir_t;
  logic        trap_v;
  logic [31:0] trap_vec;
  logic        mret_v;
  logic [31:0] mepc;
  logic        ready;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) f32 ();
  pc_gen_if #(.XLEN(32)) f16 ();

  assign f32.fetch_ready_i = ready;
  assign f16.fetch_ready_i = ready;

  logic [1:0]        mis_obs;
  logic [1:0][31:0]  ma_obs;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(32)) dut32 (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall),
    .redirect_valid_i  (redir_v),
    .redirect_target_i (redir_t),
    .trap_valid_i      (trap_v),
    .trap_vector_i     (trap_vec),
    .mret_valid_i      (mret_v),
    .mepc_i            (mepc),
    .misalign_o        (mis_obs[0]),
    .misalign_addr_o   (ma_obs[0]),
    .fetch             (f32.master)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(16)) dut16 (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall),
    .redirect_valid_i  (redir_v),
    .redirect_target_i (redir_t),
    .trap_valid_i      (trap_v),
    .trap_vector_i     (trap_vec),
    .mret_valid_i      (mret_v),
    .mepc_i            (mepc),
    .misalign_o        (mis_obs[1]),
    .misalign_addr_o   (ma_obs[1]),
    .fetch             (f16.master)
  );

  logic [1:0][31:0] pc_obs, p4_obs;
  logic [1:0]       v_obs;
  assign pc_obs[0] = f32.pc_current_o;
  assign pc_obs[1] = f16.pc_current_o;
  assign p4_obs[0] = f32.pc_plus4_o;
  assign p4_obs[1] = f16.pc_plus4_o;
  assign v_obs[0]  = f32.fetch_valid_o;
  assign v_obs[1]  = f16.fetch_valid_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model: fetching = request asserted, halted = waiting for trap.
  logic [31:0] m_pc [2];
  logic [31:0] m_ma [2];
  bit          m_mis [2];
  bit          m_booting [2];
  bit          m_halted [2];

  function automatic string nm(int k);
    return (k == 0) ? "ia32" : "ia16";
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = RV; m_ma[k] = 32'h0; m_mis[k] = 0;
      m_booting[k] = 1; m_halted[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] lowbits;
      lowbits = (k == 0) ? 32'd3 : 32'd1;
      m_mis[k] = 0;
      if (!rst_n) begin
        m_pc[k] = RV; m_ma[k] = 0; m_booting[k] = 1; m_halted[k] = 0;
      end else if (m_booting[k]) begin
        m_booting[k] = 0;
        if (trap_v) m_pc[k] = {trap_vec[31:2], 2'b00};
      end else if (m_halted[k]) begin
        if (trap_v) begin
          m_pc[k] = {trap_vec[31:2], 2'b00};
          m_halted[k] = 0;
        end
      end else if (trap_v) begin
        m_pc[k] = {trap_vec[31:2], 2'b00};
      end else if (mret_v) begin
        m_pc[k] = mepc - (mepc % (lowbits + 1));
      end else if (redir_v) begin
        if ((redir_t % (lowbits + 1)) != 0) begin
          m_mis[k] = 1; m_ma[k] = redir_t; m_halted[k] = 1;
        end else begin
          m_pc[k] = redir_t;
        end
      end else if (!stall && ready) begin
        m_pc[k] = m_pc[k] + 32'd4;
      end
    end
  endtask

  task automatic clear_inputs();
    stall = 0; redir_v = 0; redir_t = 0; trap_v = 0; trap_vec = 0;
    mret_v = 0; mepc = 0; ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== RV || v_obs[k] !== 1'b0 || mis_obs[k] !== 1'b0 || ma_obs[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state %s got pc=%h v=%b mis=%b ma=%h want pc=%h v=0 mis=0 ma=0",
                 nm(k), pc_obs[k], v_obs[k], mis_obs[k], ma_obs[k], RV);
      end
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== RV || v_obs[k] !== 1'b0) begin
        errors++;
        $display("FAIL boot_cycle0 %s got pc=%h v=%b want pc=%h v=0", nm(k), pc_obs[k], v_obs[k], RV);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pc_obs[k] !== RV + 32'(4 * i) || v_obs[k] !== 1'b1) begin
          errors++;
          $display("FAIL boot_seq%0d %s got pc=%h v=%b want pc=%h v=1",
                   i, nm(k), pc_obs[k], v_obs[k], RV + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    redir_v = 1; redir_t = 32'h200;
    tick();
    redir_v = 0; ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pc_obs[k] !== 32'h200 || v_obs[k] !== 1'b1) begin
          errors++;
          $display("FAIL backpressure%0d %s got pc=%h v=%b want pc=00000200 v=1", i, nm(k), pc_obs[k], v_obs[k]);
        end
      end
    end
    stall = 1; ready = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pc_obs[k] !== 32'h200) begin
          errors++;
          $display("FAIL stall%0d %s got pc=%h want pc=00000200", i, nm(k), pc_obs[k]);
        end
      end
    end
    stall = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'h204 || p4_obs[k] !== 32'h208) begin
        errors++;
        $display("FAIL stall_release %s got pc=%h p4=%h want pc=00000204 p4=00000208", nm(k), pc_obs[k], p4_obs[k]);
      end
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    trap_v = 1; trap_vec = 32'h8000_0003;
    mret_v = 1; mepc = 32'h40;
    redir_v = 1; redir_t = 32'h300;
    stall = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'h8000_0000) begin
        errors++;
        $display("FAIL prio_trap %s got pc=%h want pc=80000000", nm(k), pc_obs[k]);
      end
    end
    clear_inputs();
    mret_v = 1; mepc = 32'h43; redir_v = 1; redir_t = 32'h300;
    tick();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] want;
      want = (k == 0) ? 32'h40 : 32'h42;
      checks++;
      if (pc_obs[k] !== want) begin
        errors++;
        $display("FAIL prio_mret %s got pc=%h want pc=%h", nm(k), pc_obs[k], want);
      end
    end
    clear_inputs();
  endtask

  task automatic test_misalign();
    clear_inputs();
    redir_v = 1; redir_t = 32'h500;
    tick();
    redir_t = 32'h1002;
    tick();
    checks++;
    if (pc_obs[0] !== 32'h500 || mis_obs[0] !== 1'b1 || ma_obs[0] !== 32'h1002 || v_obs[0] !== 1'b0) begin
      errors++;
      $display("FAIL mis32_detect got pc=%h mis=%b ma=%h v=%b want pc=00000500 mis=1 ma=00001002 v=0",
               pc_obs[0], mis_obs[0], ma_obs[0], v_obs[0]);
    end
    checks++;
    if (pc_obs[1] !== 32'h1002 || mis_obs[1] !== 1'b0 || v_obs[1] !== 1'b1) begin
      errors++;
      $display("FAIL mis16_accept got pc=%h mis=%b v=%b want pc=00001002 mis=0 v=1", pc_obs[1], mis_obs[1], v_obs[1]);
    end
    redir_t = 32'h600;
    tick();
    checks++;
    if (pc_obs[0] !== 32'h500 || mis_obs[0] !== 1'b0 || ma_obs[0] !== 32'h1002 || v_obs[0] !== 1'b0) begin
      errors++;
      $display("FAIL mis32_halt got pc=%h mis=%b ma=%h v=%b want pc=00000500 mis=0 ma=00001002 v=0",
               pc_obs[0], mis_obs[0], ma_obs[0], v_obs[0]);
    end
    checks++;
    if (pc_obs[1] !== 32'h600) begin
      errors++;
      $display("FAIL mis16_redirect got pc=%h want pc=00000600", pc_obs[1]);
    end
    redir_v = 0; trap_v = 1; trap_vec = 32'h700;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'h700 || v_obs[k] !== 1'b1) begin
        errors++;
        $display("FAIL mis_trap_exit %s got pc=%h v=%b want pc=00000700 v=1", nm(k), pc_obs[k], v_obs[k]);
      end
    end
    trap_v = 0; redir_v = 1; redir_t = 32'h1001;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'h700 || mis_obs[k] !== 1'b1 || ma_obs[k] !== 32'h1001 || v_obs[k] !== 1'b0) begin
        errors++;
        $display("FAIL mis_odd %s got pc=%h mis=%b ma=%h v=%b want pc=00000700 mis=1 ma=00001001 v=0",
                 nm(k), pc_obs[k], mis_obs[k], ma_obs[k], v_obs[k]);
      end
    end
    redir_v = 0; trap_v = 1; trap_vec = 32'h0;
    tick();
    // Trap together with a misaligned redirect while running: no pulse.
    trap_vec = 32'h800; redir_v = 1; redir_t = 32'h2003;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'h800 || mis_obs[k] !== 1'b0 || ma_obs[k] !== 32'h1001 || v_obs[k] !== 1'b1) begin
        errors++;
        $display("FAIL trap_vs_mis %s got pc=%h mis=%b ma=%h v=%b want pc=00000800 mis=0 ma=00001001 v=1",
                 nm(k), pc_obs[k], mis_obs[k], ma_obs[k], v_obs[k]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      trap_v   = ($urandom % 16) == 0;
      trap_vec = $urandom;
      mret_v   = ($urandom % 12) == 0;
      mepc     = $urandom;
      redir_v  = ($urandom % 5) == 0;
      redir_t  = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      stall    = ($urandom % 4) == 0;
      ready    = ($urandom % 3) != 0;
      tick();
      for (int k = 0; k < 2; k++) begin
        logic want_v;
        want_v = !m_booting[k] && !m_halted[k];
        checks++;
        if (pc_obs[k] !== m_pc[k] || p4_obs[k] !== m_pc[k] + 32'd4 || v_obs[k] !== want_v ||
            mis_obs[k] !== m_mis[k] || ma_obs[k] !== m_ma[k]) begin
          errors++;
          if (bad < 10)
            $display("FAIL random%0d %s got pc=%h p4=%h v=%b mis=%b ma=%h want pc=%h p4=%h v=%b mis=%b ma=%h",
                     i, nm(k), pc_obs[k], p4_obs[k], v_obs[k], mis_obs[k], ma_obs[k],
                     m_pc[k], m_pc[k] + 32'd4, want_v, m_mis[k], m_ma[k]);
          bad++;
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_wrap_async_reset();
    clear_inputs();
    trap_v = 1; trap_vec = 32'hFFFF_FFFC;
    tick();
    trap_v = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'hFFFF_FFFC || p4_obs[k] !== 32'h0) begin
        errors++;
        $display("FAIL wrap_p4 %s got pc=%h p4=%h want pc=fffffffc p4=00000000", nm(k), pc_obs[k], p4_obs[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'h0 || p4_obs[k] !== 32'h4) begin
        errors++;
        $display("FAIL wrap_pc %s got pc=%h p4=%h want pc=00000000 p4=00000004", nm(k), pc_obs[k], p4_obs[k]);
      end
    end
    redir_v = 1; redir_t = 32'h3;
    tick();
    redir_v = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== RV || v_obs[k] !== 1'b0 || mis_obs[k] !== 1'b0 || ma_obs[k] !== 32'h0) begin
        errors++;
        $display("FAIL async_reset %s got pc=%h v=%b mis=%b ma=%h want pc=%h v=0 mis=0 ma=0",
                 nm(k), pc_obs[k], v_obs[k], mis_obs[k], ma_obs[k], RV);
      end
    end
    @(negedge clk);
    rst_n = 1;
    trap_v = 1; trap_vec = 32'h902;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_obs[k] !== 32'h900 || v_obs[k] !== 1'b1) begin
        errors++;
        $display("FAIL boot_trap %s got pc=%h v=%b want pc=00000900 v=1", nm(k), pc_obs[k], v_obs[k]);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_priority();
    test_misalign();
    test_random();
    test_wrap_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator and successor to the plain registered PC. It holds the fetch address, selects the next PC, and drives a valid/ready fetch handshake toward instruction memory.
- Next-PC sources: sequential, branch/jump redirect, trap entry, mret return.
- Stalls, a post-reset hold cycle, and misaligned-target detection are handled internally.
- Sits between the core's control/CSR logic and the instruction-memory port.

Parameters:
XLEN, 32, datapath/address width (32 or 64).
RESET_VECTOR, {XLEN{1'b0}}, PC value loaded on reset.
IALIGN, 32, instruction alignment in bits: 32 means target[1:0] must be 0; 16 means target[0] must be 0.

Ports:
clk  input  1  core clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
stall_i  input  1  hold PC (pipeline stall).
redirect_valid_i  input  1  taken branch/jump this cycle.
redirect_target_i  input  XLEN  branch/jump target.
trap_valid_i  input  1  trap entry request.
trap_vector_i  input  XLEN  mtvec value; bits [1:0] ignored.
mret_valid_i  input  1  return-from-trap request.
mepc_i  input  XLEN  return address.
fetch_ready_i  input  1  instruction memory accepts the current address.
pc_current_o  output  XLEN  current fetch address.
pc_plus4_o  output  XLEN  pc_current_o + 4, combinational.
fetch_valid_o  output  1  pc_current_o is a valid fetch request.
misalign_o  output  1  one-cycle pulse: misaligned redirect detected.
misalign_addr_o  output  XLEN  offending target, latched.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - pc_current_o=RESET_VECTOR, fetch_valid_o=0, misalign_o=0, misalign_addr_o=0, state=BOOT.
- States:
  - BOOT: fetch_valid_o=0, PC held. Goes to RUN on the first clk edge after rst_n deasserts (exactly one hold cycle). trap_valid_i still applies in BOOT.
  - RUN: fetch_valid_o=1.
  - MIS_HALT: fetch_valid_o=0, PC frozen. Only trap_valid_i (goes to RUN) or reset leaves this state; redirect, mret and stall are ignored.
- Next-PC priority at each edge in RUN, highest first:
  - trap_valid_i: PC <= {trap_vector_i[XLEN-1:2],2'b00}.
  - mret_valid_i: PC <= mepc_i with bit0 cleared (and bit1 too when IALIGN=32).
  - redirect_valid_i with an aligned target: PC <= redirect_target_i.
  - redirect_valid_i with a misaligned target: PC unchanged; misalign_o=1 for the next cycle only; misalign_addr_o <= target; state <= MIS_HALT.
  - stall_i: PC held.
  - fetch_ready_i: PC <= PC+4.
  - Otherwise: PC held. The request stays asserted with a stable address until accepted.
- Trap, mret and redirect override stall_i and do not require fetch_ready_i (a redirect flushes the pending request).
- Arithmetic is modulo 2^XLEN: PC=2^XLEN-4 plus 4 wraps to 0, with no flag.
- pc_plus4_o tracks pc_current_o in the same cycle, with the same wrap rule.
- Simultaneous trap and misaligned redirect: trap wins and no misalign pulse is generated.
- Latency: a selected next PC appears on pc_current_o one cycle after the deciding edge.
- misalign_addr_o holds its value until the next misalign event or reset.

Test Plan:
- Reset vector and boot: RESET_VECTOR=0x100, release rst_n, hold fetch_ready_i=1 -> cycle 0 PC=0x100 with fetch_valid_o=0; then 0x100 (valid=1), 0x104, 0x108.
- Backpressure and stall: PC=0x200, fetch_ready_i=0 for 3 cycles -> PC stays 0x200 with valid=1. Then stall_i=1, fetch_ready_i=1 for 2 cycles -> PC stays 0x200. Release stall -> 0x204.
- Priority: in the same cycle assert trap_valid_i (vector 0x8000_0003), mret_valid_i (mepc 0x40) and redirect to 0x300 -> PC=0x8000_0000. Next, mret alone with mepc 0x43 -> PC=0x40.
- Misaligned redirect, IALIGN=32: redirect to 0x1002 from PC 0x500 -> PC stays 0x500, misalign_o pulses one cycle, misalign_addr_o=0x1002, fetch_valid_o=0. A later redirect to 0x600 is ignored. trap_valid_i with vector 0x700 -> PC=0x700, RUN.
- IALIGN=16: redirect to 0x1002 is accepted (PC=0x1002). Redirect to 0x1001 flags misalign.
- Wrap and async reset: PC=0xFFFF_FFFC with fetch_ready_i=1 -> next PC=0x0, pc_plus4_o=0x4. Assert rst_n=0 between clock edges -> PC=RESET_VECTOR and fetch_valid_o=0 immediately, without waiting for a clock edge.
